// File: rtl/plic_gateway.sv
// Interrupt gateway: synchronises raw lines and turns level/edge sources into
// per-source pending bits, holding each claimed source until completion.
module plic_gateway #(
  parameter int Number_of_Sources = 5,
  parameter int Interrupt_Width   = 3,
  parameter int Edge_Count_Width  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [Number_of_Sources-1:0] irq_src,
  input  logic [Number_of_Sources-1:0] Edge_Trigger,
  input  logic                         set_IP,
  input  logic                         clear_IP,
  input  logic [7:0]                   Claim_ID,
  input  logic                         Complete_Valid,
  input  logic [Interrupt_Width-1:0]   Complete_ID,
  output logic [Number_of_Sources-1:0] IP_interrupt,
  output logic [Number_of_Sources-1:0] Interrupt_Request,
  output logic [Number_of_Sources-1:0] In_Service,
  output logic [Number_of_Sources-1:0] Edge_Overflow
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  logic [Number_of_Sources-1:0] s1_reg, s2_reg, s3_reg;
  logic [Number_of_Sources-1:0] edge_det;
  logic [Number_of_Sources-1:0] claim_hit, complete_hit;

  // rst_n is an active-high reset in spite of its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= irq_src;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign edge_det = s2_reg & ~s3_reg;

  generate
    for (genvar gi = 0; gi < Number_of_Sources; gi++) begin : g_src
      localparam logic [7:0]                 ClaimId    = 8'(gi + 1);
      localparam logic [Interrupt_Width-1:0] CompleteId = Interrupt_Width'(gi + 1);

      state_t                      state_reg, state_next;
      logic [Edge_Count_Width-1:0] cnt_reg, cnt_next;
      logic                        ovf_reg, ovf_next;
      logic                        ip_reg, ins_reg;
      logic                        take_edge, take_cnt, inc;

      assign claim_hit[gi]    = clear_IP && (Claim_ID == ClaimId);
      assign complete_hit[gi] = Complete_Valid && (Complete_ID == CompleteId);

      always_ff @(posedge clk) begin
        if (rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          ip_reg    <= 1'b0;
          ins_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          ovf_reg   <= ovf_next;
          ip_reg    <= (state_next == PENDING);
          ins_reg   <= (state_next == IN_SERVICE);
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        take_edge  = 1'b0;
        take_cnt   = 1'b0;
        inc        = 1'b0;
        case (state_reg)
          IDLE: begin
            if (set_IP) begin
              if (Edge_Trigger[gi]) begin
                // A fresh edge is consumed directly; the backlog is only drawn on without one
                if (edge_det[gi]) begin
                  state_next = PENDING;
                  take_edge  = 1'b1;
                end else if (cnt_reg != '0) begin
                  state_next = PENDING;
                  take_cnt   = 1'b1;
                end
              end else if (s2_reg[gi]) begin
                state_next = PENDING;
              end
            end
          end
          PENDING:    if (claim_hit[gi])    state_next = IN_SERVICE;
          IN_SERVICE: if (complete_hit[gi]) state_next = IDLE;
          default:    state_next = IDLE;
        endcase

        if (Edge_Trigger[gi]) begin
          inc = edge_det[gi] && !take_edge;
          if (inc && !take_cnt) begin
            if (cnt_reg == '1) ovf_next = 1'b1;
            else               cnt_next = cnt_reg + Edge_Count_Width'(1);
          end else if (take_cnt && !inc) begin
            cnt_next = cnt_reg - Edge_Count_Width'(1);
          end
        end
      end

      assign IP_interrupt[gi]      = ip_reg;
      assign In_Service[gi]        = ins_reg;
      assign Edge_Overflow[gi]     = ovf_reg;
      assign Interrupt_Request[gi] = Edge_Trigger[gi] ? (cnt_reg != '0) : s2_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: directed scenarios then random traffic,
// checked cycle by cycle against a backlog-based behavioural model.
module tb_plic_gateway;
  localparam int NS   = 5;
  localparam int IW   = 3;
  localparam int ECW  = 2;
  localparam int CMAX = (1 << ECW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NS-1:0] irq_src = '0;
  logic [NS-1:0] Edge_Trigger = '0;
  logic          set_IP = 1'b0;
  logic          clear_IP = 1'b0;
  logic [7:0]    Claim_ID = '0;
  logic          Complete_Valid = 1'b0;
  logic [IW-1:0] Complete_ID = '0;
  logic [NS-1:0] IP_interrupt, Interrupt_Request, In_Service, Edge_Overflow;

  plic_gateway #(.Number_of_Sources(NS), .Interrupt_Width(IW), .Edge_Count_Width(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .Edge_Trigger(Edge_Trigger),
    .set_IP(set_IP), .clear_IP(clear_IP), .Claim_ID(Claim_ID),
    .Complete_Valid(Complete_Valid), .Complete_ID(Complete_ID),
    .IP_interrupt(IP_interrupt), .Interrupt_Request(Interrupt_Request),
    .In_Service(In_Service), .Edge_Overflow(Edge_Overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] ip;
    logic [NS-1:0] ins;
    logic [NS-1:0] ir;
    logic [NS-1:0] ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Model: state 0=idle 1=pending 2=in service; cnt is the backlog of unserved edges
  int m_st[NS];
  int m_cnt[NS];
  bit m_ovf[NS];
  bit m_s1[NS], m_s2[NS], m_s3[NS];

  task automatic model_step();
    exp_t e;
    for (int k = 0; k < NS; k++) begin
      if (rst_n) begin
        m_st[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
      end else begin
        bit edge_now, fire;
        int backlog;
        edge_now = m_s2[k] && !m_s3[k];
        if (m_st[k] == 0) begin
          if (Edge_Trigger[k]) fire = set_IP && (edge_now || m_cnt[k] > 0);
          else                 fire = set_IP && m_s2[k];
          if (fire) m_st[k] = 1;
        end else begin
          fire = 0;
          if (m_st[k] == 1 && clear_IP && int'(Claim_ID) == k + 1) m_st[k] = 2;
          else if (m_st[k] == 2 && Complete_Valid && int'(Complete_ID) == k + 1) m_st[k] = 0;
        end
        if (Edge_Trigger[k]) begin
          backlog = m_cnt[k] + (edge_now ? 1 : 0) - (fire ? 1 : 0);
          if (backlog > CMAX) begin
            backlog  = CMAX;
            m_ovf[k] = 1;
          end
          m_cnt[k] = backlog;
        end
        m_s3[k] = m_s2[k]; m_s2[k] = m_s1[k]; m_s1[k] = irq_src[k];
      end
      e.ip[k]  = (m_st[k] == 1);
      e.ins[k] = (m_st[k] == 2);
      e.ovf[k] = m_ovf[k];
      e.ir[k]  = Edge_Trigger[k] ? (m_cnt[k] > 0) : m_s2[k];
    end
    exp_q.push_back(e);
  endtask

  // Inputs are held from this negedge to the next; the model predicts the next posedge
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic claim(input int id);
    clear_IP = 1'b1; Claim_ID = 8'(id);
    step();
    clear_IP = 1'b0; Claim_ID = '0;
  endtask

  task automatic complete(input int id);
    Complete_Valid = 1'b1; Complete_ID = IW'(id);
    step();
    Complete_Valid = 1'b0; Complete_ID = '0;
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    irq_src = irq_src | m;  step(); step();
    irq_src = irq_src & ~m; step(); step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s txn %0d: got %b expected %b at %0t", name, n_txn, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set, popped against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("IP_interrupt", IP_interrupt, e.ip);
        chk("In_Service", In_Service, e.ins);
        chk("Interrupt_Request", Interrupt_Request, e.ir);
        chk("Edge_Overflow", Edge_Overflow, e.ovf);
        $display("txn %0d: ip=%b ins=%b ir=%b ovf=%b", n_txn, IP_interrupt, In_Service,
                 Interrupt_Request, Edge_Overflow);
        n_txn++;
      end
    end
  end

  initial begin
    @(negedge clk);
    rst_n = 1'b1; steps(2);
    rst_n = 1'b0;

    // Level source 2: pend, claim, complete, re-pend while still high
    set_IP = 1'b1; irq_src = 5'b00100; steps(4);
    claim(3); step(); complete(3); steps(2);
    irq_src = '0; steps(3); claim(3); complete(3); steps(2);

    // set_IP gating
    set_IP = 1'b0; irq_src = 5'b00010; steps(4);
    set_IP = 1'b1; steps(2);
    irq_src = '0; steps(3);

    // Invalid claim IDs and a completion of a merely pending source
    claim(0); claim(7); complete(2); step();
    Claim_ID = 8'd200; clear_IP = 1'b1; step(); clear_IP = 1'b0; Claim_ID = '0;
    claim(2); complete(2); steps(2);

    // Edge source 0: saturate backlog while in service, then drain it
    Edge_Trigger = 5'b00001;
    pulse(5'b00001); steps(1); claim(1);
    for (int i = 0; i < 5; i++) pulse(5'b00001);
    complete(1);
    for (int i = 0; i < 3; i++) begin
      steps(2); claim(1); complete(1);
    end
    steps(3);

    // Same-cycle claim and completion of a pending source
    pulse(5'b00001); step();
    clear_IP = 1'b1; Claim_ID = 8'd1; Complete_Valid = 1'b1; Complete_ID = 3'd1;
    step();
    clear_IP = 1'b0; Claim_ID = '0; Complete_Valid = 1'b0; Complete_ID = '0;
    steps(2); complete(1); steps(2);

    // Reset while sources 0 and 3 are in service with a backlog
    rst_n = 1'b1; step(); rst_n = 1'b0;
    Edge_Trigger = 5'b01001;
    pulse(5'b01001); claim(1); claim(4);
    pulse(5'b01001); pulse(5'b01001);
    rst_n = 1'b1; step(); rst_n = 1'b0;
    steps(6);

    // Random traffic; modes only change under reset
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 99) == 0);
      if (rst_n) Edge_Trigger = NS'($urandom);
      for (int k = 0; k < NS; k++)
        if ($urandom_range(0, 7) == 0) irq_src[k] = ~irq_src[k];
      set_IP         = ($urandom_range(0, 3) != 0);
      clear_IP       = ($urandom_range(0, 2) == 0);
      Claim_ID       = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      Complete_Valid = ($urandom_range(0, 2) == 0);
      Complete_ID    = IW'($urandom_range(0, 7));
      step();
    end
    rst_n = 1'b0; clear_IP = 1'b0; Complete_Valid = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
